// File: rtl/dom1_inv_sbox8_pipe.sv
// First-order DOM-masked inverse Skinny-128 8-bit S-box, four NOR-XOR layers,
// one register stage per layer, with a valid/ready elastic wrapper.
module dom1_inv_sbox8_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_s0,
    input  logic [7:0] in_s1,
    input  logic [7:0] r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_s0,
    output logic [7:0] out_s1
);
    localparam int DEPTH = 4;

    logic       adv;
    logic [3:0] v_reg;

    // Gate-updated output shares of each stage
    logic [7:0] f0 [DEPTH];
    logic [7:0] f1 [DEPTH];

    // Undoes the final bit swap of the forward S-box
    function automatic logic [7:0] swap12(input logic [7:0] x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    // Inverse of the forward inter-round bit permutation
    function automatic logic [7:0] pinv(input logic [7:0] y);
        return {y[5], y[4], y[0], y[3], y[1], y[7], y[6], y[2]};
    endfunction

    assign out_valid = v_reg[3];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg <= 4'b0000;
        end else if (adv) begin
            v_reg <= {v_reg[2:0], in_valid};
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [7:0] a0, a1;
            logic [1:0] c0, c1;
            logic [7:0] d0_reg, d1_reg;
            logic [1:0] t0_reg, t1_reg;
            logic [7:0] f0_next, f1_next;

            if (gi == 0) begin : g_first
                assign a0 = swap12(in_s0);
                assign a1 = swap12(in_s1);
            end else begin : g_rest
                assign a0 = pinv(f0[gi-1]);
                assign a1 = pinv(f1[gi-1]);
            end

            // Slot 0 updates bit 4 from bits 7,6; slot 1 updates bit 0 from bits 3,2.
            // Share 1 carries the complement, so NOR(x,y) = (~x1 ^ x0) & (~y1 ^ y0).
            assign c1[0] = (~a1[7] & a0[6]) ^ r[2*gi];
            assign c0[0] = (~a1[6] & a0[7]) ^ r[2*gi];
            assign c1[1] = (~a1[3] & a0[2]) ^ r[2*gi+1];
            assign c0[1] = (~a1[2] & a0[3]) ^ r[2*gi+1];

            always_ff @(posedge clk) begin
                if (adv) begin
                    d0_reg <= a0;
                    d1_reg <= a1;
                    t0_reg <= c0;
                    t1_reg <= c1;
                end
            end

            always_comb begin
                f0_next    = d0_reg;
                f1_next    = d1_reg;
                f0_next[4] = d0_reg[4] ^ (d0_reg[7] & d0_reg[6]) ^ t0_reg[0];
                f1_next[4] = d1_reg[4] ^ (~d1_reg[7] & ~d1_reg[6]) ^ t1_reg[0];
                f0_next[0] = d0_reg[0] ^ (d0_reg[3] & d0_reg[2]) ^ t0_reg[1];
                f1_next[0] = d1_reg[0] ^ (~d1_reg[3] & ~d1_reg[2]) ^ t1_reg[1];
            end

            assign f0[gi] = f0_next;
            assign f1[gi] = f1_next;
        end
    endgenerate

    assign out_s0 = f0[DEPTH-1];
    assign out_s1 = f1[DEPTH-1];
endmodule

// File: tb/tb_dom1_inv_sbox8_pipe.sv
// Directed bench for the masked inverse S-box pipeline; reference table is the
// inverse of the forward S-box built from its round definition.
module tb_dom1_inv_sbox8_pipe;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_s0;
    logic [7:0] in_s1;
    logic [7:0] r;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_s0;
    logic [7:0] out_s1;

    int passed = 0;
    int total  = 0;
    logic [7:0] inv_tab [256];

    dom1_inv_sbox8_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s0     (in_s0),
        .in_s1     (in_s1),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s0    (out_s0),
        .out_s1    (out_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fwd_s8(input logic [7:0] a);
        logic [7:0] x;
        x = a;
        for (int k = 0; k < 4; k++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            if (k < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
            else       x = {x[7:3], x[1], x[2], x[0]};
        end
        return x;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] b);
        logic [7:0] m;
        m        = 8'($urandom);
        in_valid = v;
        in_s0    = m;
        in_s1    = m ^ b;
        r        = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 8'h00);
        out_ready = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else passed++;
        next_cycle();
    endtask

    task automatic test_exhaustive();
        logic [7:0] q [$];
        logic [7:0] exp_b;
        int first_acc = -1;
        int first_out = -1;
        int n_out = 0;
        int idx = 0;
        int cyc = 0;
        out_ready = 1'b1;
        while (n_out < 256 && cyc < 400) begin
            if (idx < 256) set_in(1'b1, idx[7:0]);
            else set_in(1'b0, 8'h00);
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (first_out < 0) first_out = cyc;
                total++;
                if (q.size() == 0) begin
                    $display("FAIL exh_unexpected: got %h expected no output", out_s0 ^ out_s1);
                end else begin
                    exp_b = q.pop_front();
                    if ((out_s0 ^ out_s1) !== exp_b)
                        $display("FAIL exh_value #%0d: got %h expected %h", n_out, out_s0 ^ out_s1, exp_b);
                    else passed++;
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                q.push_back(inv_tab[idx]);
                idx++;
            end
            next_cycle();
            cyc++;
        end
        total++;
        if (first_out - first_acc !== 4)
            $display("FAIL exh_latency: got %0d expected 4", first_out - first_acc);
        else passed++;
        total++;
        if (n_out !== 256) $display("FAIL exh_count: got %0d expected 256", n_out);
        else passed++;
    endtask

    task automatic test_mask_independence();
        logic [7:0] masks [3];
        logic [7:0] seen [9];
        logic [7:0] rv;
        int distinct;
        bit got;
        masks[0] = 8'h00; masks[1] = 8'ha5; masks[2] = 8'hff;
        out_ready = 1'b1;
        for (int mi = 0; mi < 3; mi++) begin
            for (int ri = 0; ri < 3; ri++) begin
                rv = (ri == 0) ? 8'h00 : (ri == 1) ? 8'hff : 8'($urandom);
                in_valid = 1'b1;
                in_s0    = masks[mi];
                in_s1    = masks[mi] ^ 8'h4c;
                r        = rv;
                next_cycle();
                in_valid = 1'b0;
                got = 1'b0;
                for (int c = 0; c < 10 && !got; c++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        got = 1'b1;
                        seen[mi*3+ri] = out_s0;
                        total++;
                        if ((out_s0 ^ out_s1) !== 8'h01)
                            $display("FAIL mask_value m=%h r=%h: got %h expected 01", masks[mi], rv, out_s0 ^ out_s1);
                        else passed++;
                    end
                    next_cycle();
                end
                if (!got) begin
                    total++;
                    $display("FAIL mask_timeout m=%h r=%h: got no output expected one", masks[mi], rv);
                end
            end
        end
        distinct = 0;
        for (int i = 0; i < 9; i++) begin
            bit dup = 1'b0;
            for (int j = 0; j < i; j++) if (seen[j] === seen[i]) dup = 1'b1;
            if (!dup) distinct++;
        end
        total++;
        if (distinct < 2) $display("FAIL mask_shares_vary: got %0d distinct expected >=2", distinct);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] bi [3];
        logic [7:0] be [3];
        logic [7:0] h0, h1;
        int sent = 0;
        int got = 0;
        int stall = 0;
        bit stall_done = 1'b0;
        bi[0] = 8'h65; bi[1] = 8'h4c; bi[2] = 8'h6a;
        be[0] = 8'h00; be[1] = 8'h01; be[2] = 8'h02;
        h0 = 8'h00; h1 = 8'h00;
        for (int c = 0; c < 30; c++) begin
            if (sent < 3) set_in(1'b1, bi[sent]);
            else set_in(1'b0, 8'h00);
            if (out_valid === 1'b1 && !stall_done && stall == 0) begin
                stall = 5;
                h0 = out_s0;
                h1 = out_s1;
            end
            out_ready = (stall == 0);
            @(negedge clk);
            if (stall > 0) begin
                total++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready);
                else passed++;
                total++;
                if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", out_valid);
                else passed++;
                total++;
                if (out_s0 !== h0) $display("FAIL bp_hold_s0: got %h expected %h", out_s0, h0);
                else passed++;
                total++;
                if (out_s1 !== h1) $display("FAIL bp_hold_s1: got %h expected %h", out_s1, h1);
                else passed++;
            end else if (out_valid === 1'b1 && out_ready) begin
                total++;
                if (got >= 3)
                    $display("FAIL bp_duplicate: got extra %h expected none", out_s0 ^ out_s1);
                else if ((out_s0 ^ out_s1) !== be[got])
                    $display("FAIL bp_value #%0d: got %h expected %h", got, out_s0 ^ out_s1, be[got]);
                else passed++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            if (stall > 0) begin
                stall--;
                if (stall == 0) stall_done = 1'b1;
            end
            next_cycle();
        end
        total++;
        if (got !== 3) $display("FAIL bp_count: got %0d expected 3", got);
        else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_bubbles();
        logic       pv [4];
        logic [7:0] pb [4];
        logic [7:0] pe [4];
        logic       exp_v;
        pv[0] = 1'b1; pv[1] = 1'b0; pv[2] = 1'b1; pv[3] = 1'b0;
        pb[0] = 8'hff; pb[1] = 8'h00; pb[2] = 8'h65; pb[3] = 8'h00;
        pe[0] = 8'hff; pe[1] = 8'h00; pe[2] = 8'h00; pe[3] = 8'h00;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) set_in(pv[c], pb[c]);
            else set_in(1'b0, 8'h00);
            @(negedge clk);
            exp_v = (c >= 4 && c < 8) ? pv[c-4] : 1'b0;
            total++;
            if (out_valid !== exp_v)
                $display("FAIL bubble_valid cyc%0d: got %b expected %b", c, out_valid, exp_v);
            else passed++;
            if (exp_v && out_valid === 1'b1) begin
                total++;
                if ((out_s0 ^ out_s1) !== pe[c-4])
                    $display("FAIL bubble_value cyc%0d: got %h expected %h", c, out_s0 ^ out_s1, pe[c-4]);
                else passed++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        logic exp_v;
        out_ready = 1'b1;
        set_in(1'b1, 8'h65);
        next_cycle();
        set_in(1'b1, 8'h4c);
        next_cycle();
        set_in(1'b0, 8'h00);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 3; c < 13; c++) begin
            if (c == 3) set_in(1'b1, 8'h6a);
            else set_in(1'b0, 8'h00);
            @(negedge clk);
            if (c == 3) begin
                total++;
                if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready);
                else passed++;
            end
            exp_v = (c == 7);
            total++;
            if (out_valid !== exp_v)
                $display("FAIL rstmid_valid cyc%0d: got %b expected %b", c, out_valid, exp_v);
            else passed++;
            if (exp_v && out_valid === 1'b1) begin
                total++;
                if ((out_s0 ^ out_s1) !== 8'h02)
                    $display("FAIL rstmid_value: got %h expected 02", out_s0 ^ out_s1);
                else passed++;
            end
            next_cycle();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_s0     = 8'h00;
        in_s1     = 8'h00;
        r         = 8'h00;
        out_ready = 1'b1;
        for (int a = 0; a < 256; a++) inv_tab[fwd_s8(8'(a))] = 8'(a);
        test_reset();
        test_exhaustive();
        test_mask_independence();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
